// File: rtl/sub_shift_rows.sv
// ---------------------------------------------------------------------------
// sub_shift_rows
//
// Iterative AES-128 SubBytes + ShiftRows stage, or InvSubBytes + InvShiftRows
// when the latched flag is set. It sits directly in front of mixColumns.
//
// A 128-bit state is accepted on a valid/ready handshake and stored in a
// byte-wide state register. ROWS_PER_CYCLE rows are substituted per clock
// through 4*ROWS_PER_CYCLE computed S-box lanes. The (inverse) row shift is
// fixed wiring from the register to out_state. The result is held on
// out_valid until the downstream accepts it.
//
// Parameters:
//   ROWS_PER_CYCLE  rows substituted per clock (1, 2 or 4)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_state/in_flag valid
//   in_ready   block can accept a state this cycle
//   in_state   AES state, row-major; byte (r,c) = bits [127-32r-8c -: 8]
//   in_flag    0 = forward, 1 = inverse
//   out_valid  out_state/out_flag valid
//   out_ready  downstream accepts
//   out_state  substituted and shifted state
//   out_flag   flag latched with this state
// ---------------------------------------------------------------------------
module sub_shift_rows #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_flag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_flag
);

    localparam int NSUB  = 4 / ROWS_PER_CYCLE;
    localparam int LANES = 4 * ROWS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

    fsm_t       fsm_reg;
    logic [1:0] cnt_reg;
    logic       flag_reg;
    logic [7:0] state_reg [16];

    logic [7:0] in_bytes [16];
    logic [7:0] sub_next [16];
    logic [7:0] lane_out [LANES];
    logic [3:0] lane_idx [LANES];

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0
    // naturally, so no special case is needed.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // ------------------------------------------------------------------
    // Input unpacking
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_unpack
            assign in_bytes[gi] = in_state[127 - 8*gi -: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // S-box lanes. Each lane owns one byte column of one of the rows
    // currently being substituted; the affine stages are muxed around a
    // single inverter so forward and inverse share the expensive part.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LR = gi / 4;
            localparam int LC = gi % 4;
            logic [1:0] row_sel;
            logic [7:0] lane_in;
            logic [7:0] inv_in;
            logic [7:0] inv_out;

            assign row_sel       = 2'(int'(cnt_reg) * ROWS_PER_CYCLE + LR);
            assign lane_idx[gi]  = {row_sel, 2'(LC)};
            assign lane_in       = state_reg[lane_idx[gi]];
            assign inv_in        = flag_reg ? inv_affine(lane_in) : lane_in;
            assign inv_out       = gf_inv(inv_in);
            assign lane_out[gi]  = flag_reg ? inv_out : fwd_affine(inv_out);
        end
    endgenerate

    // Register image after one substitution step: untouched rows pass through.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sub_next[i] = state_reg[i];
        end
        for (int l = 0; l < LANES; l++) begin
            sub_next[lane_idx[l]] = lane_out[l];
        end
    end

    // ------------------------------------------------------------------
    // Output: fixed (inverse) ShiftRows wiring from the state register.
    // Forward: out(r,c) = reg(r,(c+r)%4); inverse: out(r,c) = reg(r,(c-r)%4).
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam int R       = gi / 4;
            localparam int C       = gi % 4;
            localparam int FWD_SRC = R*4 + (C + R) % 4;
            localparam int INV_SRC = R*4 + (C + 4 - R) % 4;
            assign out_state[127 - 8*gi -: 8] = flag_reg ? state_reg[INV_SRC]
                                                         : state_reg[FWD_SRC];
        end
    endgenerate

    assign out_flag  = flag_reg;
    assign out_valid = (fsm_reg == DONE);
    // In DONE a new block can enter on the same edge the result leaves.
    assign in_ready  = (fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready);

    // ------------------------------------------------------------------
    // Control FSM and state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg  <= IDLE;
            cnt_reg  <= 2'd0;
            flag_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                state_reg[i] <= 8'h00;
            end
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            state_reg[i] <= in_bytes[i];
                        end
                        flag_reg <= in_flag;
                        cnt_reg  <= 2'd0;
                        fsm_reg  <= SUB;
                    end
                end
                SUB: begin
                    for (int i = 0; i < 16; i++) begin
                        state_reg[i] <= sub_next[i];
                    end
                    if (cnt_reg == 2'(NSUB - 1)) begin
                        cnt_reg <= 2'd0;
                        fsm_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            for (int i = 0; i < 16; i++) begin
                                state_reg[i] <= in_bytes[i];
                            end
                            flag_reg <= in_flag;
                            cnt_reg  <= 2'd0;
                            fsm_reg  <= SUB;
                        end else begin
                            fsm_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
